// File: rtl/arp_dispatch_pkg.sv
// Shared types and field layout for the ARP-resolving packet dispatcher.
// Header word: flag in bit 32, payload length above bit 8, port code in the low bits.
package arp_dispatch_pkg;

    localparam int WORD_W       = 33;
    localparam int HDR_FLAG_BIT = 32;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_PORT_LSB = 0;
    localparam int MAC_W        = 48;
    localparam int MAC_LO_W     = 16;
    localparam int MAC_HI_W     = MAC_W - MAC_LO_W;

    typedef enum logic [2:0] {
        HUNT,
        RD_IP,
        WAIT_ARP_RES,
        SEND_MAC_H,
        SEND_MAC_L,
        SEND_DATA,
        DEL_DATA
    } state_t;

    // MAC high half travels as a header-flagged word so ports can frame on it.
    function automatic logic [WORD_W-1:0] mac_hi_word(input logic [MAC_W-1:0] mac);
        return {1'b1, mac[MAC_W-1 -: MAC_HI_W]};
    endfunction

    function automatic logic [WORD_W-1:0] mac_lo_word(input logic [MAC_W-1:0] mac);
        return {{(WORD_W-MAC_LO_W){1'b0}}, mac[MAC_LO_W-1:0]};
    endfunction

endpackage

// File: rtl/arp_wait_timer.sv
// Cycle counter bounding the wait for an ARP answer; expire is high on the TIMEOUT-th cycle
// after a clear, i.e. when the count reaches TIMEOUT-1, and the count holds there.
module arp_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + ONE;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/arp_dispatch_param.sv
// Dispatches FWFT-FIFO packets to NUM_PORTS ports after ARP resolution, prepending the MAC.
// Output words are registered (1 cycle after pop); an empty FIFO simply stalls the pop.
module arp_dispatch_param
    import arp_dispatch_pkg::*;
#(
    parameter int NUM_PORTS   = 8,
    parameter int PORT_W      = 4,
    parameter int LEN_W       = 6,
    parameter int ARP_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_net,
    input  logic                 rst_n,
    input  logic [WORD_W-1:0]    fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [31:0]          arp_ip_dout,
    output logic [PORT_W-1:0]    arp_port_num_dout,
    output logic                 arp_dout_en,
    input  logic [MAC_W-1:0]     arp_mac_din,
    input  logic                 arp_mac_din_en,
    input  logic                 arp_del_din_en,
    output logic [WORD_W-1:0]    dout_33bit,
    output logic [NUM_PORTS-1:0] dout_port_en,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [LEN_W:0] REM_ONE = (LEN_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state_q, state_d;

    logic [PORT_W-1:0]    port_q, port_d;
    logic [LEN_W:0]       rem_q, rem_d;
    logic [MAC_W-1:0]     mac_q, mac_d;

    logic                 head_vld;
    logic                 head_hdr;
    logic [LEN_W-1:0]     hdr_len;
    logic [PORT_W-1:0]    hdr_port;
    logic                 hdr_port_ok;

    logic                 pop;
    logic                 ip_load;
    logic                 word_vld;
    logic [WORD_W-1:0]    word_d;
    logic                 drop_inc;
    logic                 err_inc;
    logic                 tmr_expire;
    logic [NUM_PORTS-1:0] port_oh;

    assign head_vld    = !fifo_empty;
    assign head_hdr    = fifo_dout[HDR_FLAG_BIT];
    assign hdr_len     = fifo_dout[HDR_LEN_LSB +: LEN_W];
    assign hdr_port    = fifo_dout[HDR_PORT_LSB +: PORT_W];
    assign hdr_port_ok = (hdr_port != '0) && (int'(hdr_port) <= NUM_PORTS);

    assign fifo_rd_en  = pop;

    arp_wait_timer #(
        .TIMEOUT (ARP_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk_net),
        .rst_n  (rst_n),
        .clr    (state_q != WAIT_ARP_RES),
        .en     (state_q == WAIT_ARP_RES),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk_net or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            port_q  <= '0;
            rem_q   <= '0;
            mac_q   <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            rem_q   <= rem_d;
            mac_q   <= mac_d;
        end
    end

    // Every pop is gated by head_vld, so the FIFO is never read while empty.
    always_comb begin
        state_d  = state_q;
        port_d   = port_q;
        rem_d    = rem_q;
        mac_d    = mac_q;
        pop      = 1'b0;
        ip_load  = 1'b0;
        word_vld = 1'b0;
        word_d   = '0;
        drop_inc = 1'b0;
        err_inc  = 1'b0;

        case (state_q)
            HUNT: begin
                if (head_vld) begin
                    pop = 1'b1;
                    if (!head_hdr) begin
                        err_inc = 1'b1;
                    end else begin
                        port_d = hdr_port;
                        if (hdr_port_ok) begin
                            rem_d   = {1'b0, hdr_len};
                            state_d = RD_IP;
                        end else begin
                            // IP word is discarded along with the payload.
                            rem_d    = {1'b0, hdr_len} + REM_ONE;
                            drop_inc = 1'b1;
                            state_d  = DEL_DATA;
                        end
                    end
                end
            end

            RD_IP: begin
                if (head_vld) begin
                    pop     = 1'b1;
                    ip_load = 1'b1;
                    state_d = WAIT_ARP_RES;
                end
            end

            WAIT_ARP_RES: begin
                // A response arriving on the expiry cycle still counts.
                if (arp_del_din_en) begin
                    drop_inc = 1'b1;
                    state_d  = DEL_DATA;
                end else if (arp_mac_din_en) begin
                    mac_d   = arp_mac_din;
                    state_d = SEND_MAC_H;
                end else if (tmr_expire) begin
                    drop_inc = 1'b1;
                    state_d  = DEL_DATA;
                end
            end

            SEND_MAC_H: begin
                word_vld = 1'b1;
                word_d   = mac_hi_word(mac_q);
                state_d  = SEND_MAC_L;
            end

            SEND_MAC_L: begin
                word_vld = 1'b1;
                word_d   = mac_lo_word(mac_q);
                state_d  = (rem_q == '0) ? HUNT : SEND_DATA;
            end

            SEND_DATA: begin
                if (head_vld) begin
                    if (head_hdr) begin
                        // Truncated packet: leave the new header for HUNT.
                        err_inc = 1'b1;
                        state_d = HUNT;
                    end else begin
                        pop      = 1'b1;
                        word_vld = 1'b1;
                        word_d   = {1'b0, fifo_dout[WORD_W-2:0]};
                        rem_d    = rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_d = HUNT;
                        end
                    end
                end
            end

            DEL_DATA: begin
                if (rem_q == '0) begin
                    state_d = HUNT;
                end else if (head_vld) begin
                    if (head_hdr) begin
                        state_d = HUNT;
                    end else begin
                        pop   = 1'b1;
                        rem_d = rem_q - REM_ONE;
                        if (rem_q == REM_ONE) begin
                            state_d = HUNT;
                        end
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_comb begin
        port_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_oh[i] = (int'(port_q) == i + 1);
        end
    end

    always_ff @(posedge clk_net or negedge rst_n) begin
        if (!rst_n) begin
            dout_33bit   <= '0;
            dout_port_en <= '0;
        end else begin
            dout_33bit   <= word_d;
            dout_port_en <= word_vld ? port_oh : '0;
        end
    end

    always_ff @(posedge clk_net or negedge rst_n) begin
        if (!rst_n) begin
            arp_ip_dout       <= '0;
            arp_port_num_dout <= '0;
            arp_dout_en       <= 1'b0;
        end else begin
            arp_dout_en <= ip_load;
            if (ip_load) begin
                arp_ip_dout       <= fifo_dout[31:0];
                arp_port_num_dout <= port_q;
            end
        end
    end

    always_ff @(posedge clk_net or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (drop_inc && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
            if (err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule
